// File: rtl/food_placer_pkg.sv
// rtl/food_placer_pkg.sv - shared constants and state encoding for food placement
// Purpose: default geometry/try limits and the placer FSM state type.
// Ports: none (package).
package food_placer_pkg;

  localparam int DEF_COORD_W   = 4;
  localparam int DEF_GRID_W    = 16;
  localparam int DEF_GRID_H    = 16;
  localparam int DEF_MAX_TRIES = 8;

  // Wide enough for MAX_TRIES up to 255.
  localparam int TRY_W = 8;

  typedef enum logic [1:0] {
    FP_IDLE   = 2'd0,
    FP_SAMPLE = 2'd1,
    FP_QUERY  = 2'd2,
    FP_SCAN   = 2'd3
  } fp_state_t;

endpackage

// File: rtl/food_scan_ctr.sv
// rtl/food_scan_ctr.sv - raster-order cell counter for fallback scan
// Purpose: walks (0,0),(1,0)..(GRID_W-1,0),(0,1).. and flags the last cell.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_clr            restart at (0,0)
//   i_step           advance to the next cell
//   o_nxt_x/o_nxt_y  cell that follows the current one
//   o_done           current cell is (GRID_W-1, GRID_H-1)
module food_scan_ctr #(
  parameter int COORD_W = 4,
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_step,
  output logic [COORD_W-1:0] o_nxt_x,
  output logic [COORD_W-1:0] o_nxt_y,
  output logic               o_done
);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               x_last;

  assign x_last = (x_q == COORD_W'(GRID_W - 1));
  assign o_done = x_last && (y_q == COORD_W'(GRID_H - 1));

  always_comb begin
    o_nxt_x = x_q + 1'b1;
    o_nxt_y = y_q;
    if (x_last) begin
      o_nxt_x = '0;
      o_nxt_y = y_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (i_step) begin
      x_q <= o_nxt_x;
      y_q <= o_nxt_y;
    end
  end

endmodule

// File: rtl/food_placer.sv
// rtl/food_placer.sv - food placement sequencer with occupancy query port
// Purpose: on a place request, samples LFSR coordinates, rejects off-grid
//   candidates, queries occupancy via req/ack and publishes the first free cell.
//   Build option FOOD_SCAN_FALLBACK_EN: after MAX_TRIES misses, raster-scan the
//   grid from (0,0); without it, exhaustion pulses o_fail.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_place_req              1-cycle placement request
//   i_rand_x, i_rand_y       LFSR coordinates
//   o_occ_req/o_occ_x/o_occ_y occupancy query; i_occ_ack/i_occ_hit answer
//   o_food_x/o_food_y/o_food_valid  published food cell
//   o_busy                   placement in progress
//   o_fail                   1-cycle pulse when no free cell was found
module food_placer #(
  parameter int COORD_W   = food_placer_pkg::DEF_COORD_W,
  parameter int GRID_W    = food_placer_pkg::DEF_GRID_W,
  parameter int GRID_H    = food_placer_pkg::DEF_GRID_H,
  parameter int MAX_TRIES = food_placer_pkg::DEF_MAX_TRIES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_place_req,
  input  logic [COORD_W-1:0] i_rand_x,
  input  logic [COORD_W-1:0] i_rand_y,
  output logic               o_occ_req,
  output logic [COORD_W-1:0] o_occ_x,
  output logic [COORD_W-1:0] o_occ_y,
  input  logic               i_occ_ack,
  input  logic               i_occ_hit,
  output logic [COORD_W-1:0] o_food_x,
  output logic [COORD_W-1:0] o_food_y,
  output logic               o_food_valid,
  output logic               o_busy,
  output logic               o_fail
);
  import food_placer_pkg::*;

  fp_state_t          state, state_nxt;
  logic [TRY_W-1:0]   tries, tries_nxt, tries_inc;
  logic [COORD_W-1:0] occ_x_nxt, occ_y_nxt, food_x_nxt, food_y_nxt;
  logic               occ_req_nxt, food_valid_nxt, fail_nxt;
  logic               cand_in_bounds, exhaust;

  assign tries_inc      = tries + 1'b1;
  assign cand_in_bounds = (int'(i_rand_x) < GRID_W) && (int'(i_rand_y) < GRID_H);

`ifdef FOOD_SCAN_FALLBACK_EN
  logic               scan_clr, scan_step, scan_done;
  logic [COORD_W-1:0] scan_nxt_x, scan_nxt_y;

  food_scan_ctr #(.COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (scan_clr),
    .i_step  (scan_step),
    .o_nxt_x (scan_nxt_x),
    .o_nxt_y (scan_nxt_y),
    .o_done  (scan_done)
  );
`endif

  always_comb begin
    state_nxt      = state;
    tries_nxt      = tries;
    occ_req_nxt    = o_occ_req;
    occ_x_nxt      = o_occ_x;
    occ_y_nxt      = o_occ_y;
    food_x_nxt     = o_food_x;
    food_y_nxt     = o_food_y;
    food_valid_nxt = o_food_valid;
    fail_nxt       = 1'b0;
    exhaust        = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
    scan_clr       = 1'b0;
    scan_step      = 1'b0;
`endif
    case (state)
      FP_IDLE: begin
        if (i_place_req) begin
          state_nxt      = FP_SAMPLE;
          food_valid_nxt = 1'b0;
          tries_nxt      = '0;
        end
      end
      FP_SAMPLE: begin
        occ_x_nxt = i_rand_x;
        occ_y_nxt = i_rand_y;
        tries_nxt = tries_inc;
        if (cand_in_bounds) begin
          state_nxt   = FP_QUERY;
          occ_req_nxt = 1'b1;
        end else if (tries_inc >= TRY_W'(MAX_TRIES)) begin
          exhaust = 1'b1;
        end
      end
      FP_QUERY: begin
        if (i_occ_ack) begin
          occ_req_nxt = 1'b0;
          if (!i_occ_hit) begin
            food_x_nxt     = o_occ_x;
            food_y_nxt     = o_occ_y;
            food_valid_nxt = 1'b1;
            state_nxt      = FP_IDLE;
          end else if (tries < TRY_W'(MAX_TRIES)) begin
            state_nxt = FP_SAMPLE;
          end else begin
            exhaust = 1'b1;
          end
        end
      end
`ifdef FOOD_SCAN_FALLBACK_EN
      FP_SCAN: begin
        // Request stays up across cells; each ack closes one cell's query.
        if (i_occ_ack) begin
          if (!i_occ_hit) begin
            food_x_nxt     = o_occ_x;
            food_y_nxt     = o_occ_y;
            food_valid_nxt = 1'b1;
            occ_req_nxt    = 1'b0;
            state_nxt      = FP_IDLE;
          end else if (scan_done) begin
            fail_nxt    = 1'b1;
            occ_req_nxt = 1'b0;
            state_nxt   = FP_IDLE;
          end else begin
            scan_step = 1'b1;
            occ_x_nxt = scan_nxt_x;
            occ_y_nxt = scan_nxt_y;
          end
        end
      end
`endif
      default: state_nxt = FP_IDLE;
    endcase

    if (exhaust) begin
`ifdef FOOD_SCAN_FALLBACK_EN
      state_nxt   = FP_SCAN;
      occ_req_nxt = 1'b1;
      occ_x_nxt   = '0;
      occ_y_nxt   = '0;
      scan_clr    = 1'b1;
`else
      state_nxt   = FP_IDLE;
      occ_req_nxt = 1'b0;
      fail_nxt    = 1'b1;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= FP_IDLE;
      tries        <= '0;
      o_occ_req    <= 1'b0;
      o_occ_x      <= '0;
      o_occ_y      <= '0;
      o_food_x     <= '0;
      o_food_y     <= '0;
      o_food_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_fail       <= 1'b0;
    end else begin
      state        <= state_nxt;
      tries        <= tries_nxt;
      o_occ_req    <= occ_req_nxt;
      o_occ_x      <= occ_x_nxt;
      o_occ_y      <= occ_y_nxt;
      o_food_x     <= food_x_nxt;
      o_food_y     <= food_y_nxt;
      o_food_valid <= food_valid_nxt;
      o_busy       <= (state_nxt != FP_IDLE);
      o_fail       <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - self-checking bench for food_placer
module tb_food_placer;

  localparam int CW = 4, GW = 10, GH = 12, MT = 8, LOGN = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0, place_req = 1'b0, occ_ack = 1'b0, occ_hit = 1'b0;
  logic [CW-1:0] rand_x = 4'd1, rand_y = 4'd1;
  logic occ_req, food_valid, busy, fail;
  logic [CW-1:0] occ_x, occ_y, food_x, food_y;

  food_placer #(.COORD_W(CW), .GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_place_req(place_req),
    .i_rand_x(rand_x), .i_rand_y(rand_y),
    .o_occ_req(occ_req), .o_occ_x(occ_x), .o_occ_y(occ_y),
    .i_occ_ack(occ_ack), .i_occ_hit(occ_hit),
    .o_food_x(food_x), .o_food_y(food_y), .o_food_valid(food_valid),
    .o_busy(busy), .o_fail(fail)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit occ [16][16];
  logic [CW-1:0] sx [LOGN], sy [LOGN];
  int fixed_delay;
  bit spurious, timed_out;
  int ncyc;
  bit l_req [LOGN], l_ack [LOGN], l_valid [LOGN], l_busy [LOGN], l_fail [LOGN];
  logic [CW-1:0] l_ox [LOGN], l_oy [LOGN], l_fx [LOGN], l_fy [LOGN];

  typedef struct {
    logic [CW-1:0] x0, y0, x1, y1;
    int            dly;
    logic [CW-1:0] fx, fy;
    int            lat;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_occ();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) occ[i][j] = 1'b0;
  endtask

  // Cycle 0 carries the request; outputs logged per cycle, responder acks
  // combinationally from the observed query.
  task automatic run_req(input int max_cyc);
    int wait_left;
    wait_left = -1;
    timed_out = 1'b1;
    ncyc = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk); #1;
      l_req[k] = occ_req; l_ox[k] = occ_x; l_oy[k] = occ_y;
      l_valid[k] = food_valid; l_busy[k] = busy; l_fail[k] = fail;
      l_fx[k] = food_x; l_fy[k] = food_y;
      ncyc = k + 1;
      if (k >= 1 && !busy) begin
        place_req = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
        l_ack[k] = 1'b0;
        timed_out = 1'b0;
        break;
      end
      place_req = (k == 0) ? 1'b1 : (spurious && $urandom_range(0, 9) == 0);
      rand_x = sx[k]; rand_y = sy[k];
      occ_ack = 1'b0; occ_hit = 1'b0;
      if (occ_req) begin
        if (wait_left < 0) wait_left = (fixed_delay < 0) ? int'($urandom_range(0, 2)) : fixed_delay;
        if (wait_left == 0) begin
          occ_ack = 1'b1; occ_hit = occ[occ_x][occ_y]; wait_left = -1;
        end else wait_left--;
      end else if (spurious) begin
        occ_ack = ($urandom_range(0, 3) == 0); occ_hit = 1'($urandom_range(0, 1));
      end
      l_ack[k] = occ_ack;
    end
    place_req = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
  endtask

  function automatic int count_q();
    int n = 0;
    for (int k = 0; k < ncyc; k++) if (l_req[k] && l_ack[k]) n++;
    return n;
  endfunction

  // Query for (x,y) must be presented from cycle st until acked; returns ack cycle.
  function automatic bit query_ok(input int st, input logic [CW-1:0] x, input logic [CW-1:0] y, output int a);
    a = -1;
    for (int k = st; k < ncyc; k++) begin
      if (!(l_req[k] && l_ox[k] == x && l_oy[k] == y)) return 1'b0;
      if (l_ack[k]) begin a = k; return 1'b1; end
    end
    return 1'b0;
  endfunction

  task automatic check_req();
    int s, tries, a, e, exp_end, nfail;
    bit done, exhaust, ok, exp_valid, exp_fail;
    logic [CW-1:0] cx, cy, efx, efy;
`ifdef FOOD_SCAN_FALLBACK_EN
    int q;
    bit found;
`endif
    s = 1; tries = 0; done = 0; exhaust = 0; ok = 1; exp_valid = 0; exp_fail = 0;
    exp_end = -1; efx = 0; efy = 0; e = 0; a = 0;
    while (!done && ok) begin
      cx = sx[s]; cy = sy[s]; tries++;
      if (int'(cx) >= GW || int'(cy) >= GH) begin
        if (tries < MT) s++; else begin exhaust = 1; e = s; done = 1; end
      end else if (!query_ok(s + 1, cx, cy, a)) ok = 0;
      else if (!occ[cx][cy]) begin exp_valid = 1; efx = cx; efy = cy; exp_end = a + 1; done = 1; end
      else if (tries < MT) s = a + 1;
      else begin exhaust = 1; e = a; done = 1; end
    end
    if (ok && exhaust) begin
`ifdef FOOD_SCAN_FALLBACK_EN
      q = e + 1; found = 0;
      for (int c = 0; c < GW * GH && ok && !found; c++) begin
        cx = CW'(c % GW); cy = CW'(c / GW);
        if (!query_ok(q, cx, cy, a)) ok = 0;
        else if (!occ[cx][cy]) begin found = 1; exp_valid = 1; efx = cx; efy = cy; exp_end = a + 1; end
        else q = a + 1;
      end
      if (ok && !found) begin exp_fail = 1; exp_end = q; end
`else
      exp_fail = 1; exp_end = e + 1;
`endif
    end
    check("rnd_query_seq", 32'(ok), 1);
    if (ok) begin
      check("rnd_end_cycle", ncyc - 1, exp_end);
      check("rnd_valid", 32'(l_valid[ncyc-1]), 32'(exp_valid));
      check("rnd_fail", 32'(l_fail[ncyc-1]), 32'(exp_fail));
      if (exp_valid) begin
        check("rnd_food_x", 32'(l_fx[ncyc-1]), 32'(efx));
        check("rnd_food_y", 32'(l_fy[ncyc-1]), 32'(efy));
      end
      nfail = 0;
      for (int k = 0; k < ncyc; k++) if (l_fail[k]) nfail++;
      check("rnd_fail_count", nfail, 32'(exp_fail));
    end
  endtask

  initial begin
    vt[0] = '{4'd5,  4'd7,  4'd5, 4'd7, 0, 4'd5,  4'd7,  3};
    vt[1] = '{4'd12, 4'd4,  4'd4, 4'd4, 0, 4'd4,  4'd4,  4};
    vt[2] = '{4'd9,  4'd11, 4'd1, 4'd1, 2, 4'd9,  4'd11, 5};
    vt[3] = '{4'd10, 4'd3,  4'd1, 4'd1, 0, 4'd1,  4'd1,  4};
    vt[4] = '{4'd3,  4'd12, 4'd2, 4'd2, 1, 4'd2,  4'd2,  5};
    vt[5] = '{4'd15, 4'd15, 4'd1, 4'd2, 0, 4'd1,  4'd2,  4};

    // Reset held two cycles, then released.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_occ_req", 32'(occ_req), 0);
    check("rst_food_x", 32'(food_x), 0);
    check("rst_food_y", 32'(food_y), 0);
    check("rst_valid", 32'(food_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fail", 32'(fail), 0);

    // Single-candidate vectors, all cells free.
    spurious = 1'b0;
    clear_occ();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 64; k++) begin
        sx[k] = (k <= 1) ? vt[i].x0 : vt[i].x1;
        sy[k] = (k <= 1) ? vt[i].y0 : vt[i].y1;
      end
      fixed_delay = vt[i].dly;
      run_req(64);
      check($sformatf("vec%0d_timeout", i), 32'(timed_out), 0);
      check($sformatf("vec%0d_latency", i), ncyc - 1, vt[i].lat);
      check($sformatf("vec%0d_valid_cleared", i), 32'(l_valid[1]), 0);
      check($sformatf("vec%0d_valid", i), 32'(l_valid[ncyc-1]), 1);
      check($sformatf("vec%0d_food_x", i), 32'(l_fx[ncyc-1]), 32'(vt[i].fx));
      check($sformatf("vec%0d_food_y", i), 32'(l_fy[ncyc-1]), 32'(vt[i].fy));
      check($sformatf("vec%0d_queries", i), count_q(), 1);
    end

    // Two occupied candidates, third (9,3) free.
    clear_occ();
    occ[2][2] = 1'b1; occ[6][6] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      sx[k] = (k <= 2) ? 4'd2 : ((k <= 4) ? 4'd6 : 4'd9);
      sy[k] = (k <= 2) ? 4'd2 : ((k <= 4) ? 4'd6 : 4'd3);
    end
    fixed_delay = 0;
    run_req(64);
    check("retry_end_cycle", ncyc - 1, 7);
    check("retry_food_x", 32'(l_fx[ncyc-1]), 9);
    check("retry_food_y", 32'(l_fy[ncyc-1]), 3);
    check("retry_queries", count_q(), 3);

    // Every random candidate occupied.
    clear_occ();
    occ[5][5] = 1'b1;
    occ[0][0] = 1'b1; occ[1][0] = 1'b1; occ[2][0] = 1'b1;
    for (int k = 0; k < 128; k++) begin sx[k] = 4'd5; sy[k] = 4'd5; end
    fixed_delay = 0;
    run_req(128);
`ifdef FOOD_SCAN_FALLBACK_EN
    begin
      int n;
      logic [CW-1:0] qx [16], qy [16];
      n = 0;
      for (int k = 0; k < ncyc; k++)
        if (l_req[k] && l_ack[k] && n < 16) begin qx[n] = l_ox[k]; qy[n] = l_oy[k]; n++; end
      check("scan_queries", n, 12);
      for (int j = 0; j < 4; j++) begin
        check($sformatf("scan_order%0d_x", j), 32'(qx[8+j]), j);
        check($sformatf("scan_order%0d_y", j), 32'(qy[8+j]), 0);
      end
      check("scan_end_cycle", ncyc - 1, 21);
      check("scan_food_x", 32'(l_fx[ncyc-1]), 3);
      check("scan_food_y", 32'(l_fy[ncyc-1]), 0);
      check("scan_valid", 32'(l_valid[ncyc-1]), 1);
    end
`else
    check("exhaust_queries", count_q(), 8);
    check("exhaust_end_cycle", ncyc - 1, 17);
    check("exhaust_fail", 32'(l_fail[ncyc-1]), 1);
    check("exhaust_valid", 32'(l_valid[ncyc-1]), 0);
    @(posedge clk); #1;
    check("exhaust_fail_width", 32'(fail), 0);
`endif

    // Reset while a query is outstanding.
    place_req = 1'b1; rand_x = 4'd5; rand_y = 4'd7;
    @(posedge clk); #1 place_req = 1'b0;
    @(posedge clk); #1;
    check("rstq_req_up", 32'(occ_req), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstq_req", 32'(occ_req), 0);
    check("rstq_busy", 32'(busy), 0);
    check("rstq_valid", 32'(food_valid), 0);
    rst_n = 1'b1;

    // Randomized requests with random ack delays and stray inputs.
    spurious = 1'b1;
    fixed_delay = -1;
    for (int r = 0; r < 40; r++) begin
      int dens, pct;
      dens = $urandom_range(0, 3);
      pct = (dens == 0) ? 30 : ((dens == 3) ? 100 : 80);
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) occ[i][j] = ($urandom_range(0, 99) < pct);
      for (int k = 0; k < LOGN; k++) begin
        sx[k] = CW'($urandom_range(1, 15)); sy[k] = CW'($urandom_range(1, 15));
      end
      run_req(LOGN);
      check("rnd_timeout", 32'(timed_out), 0);
      if (!timed_out) check_req();
      @(posedge clk); #1;
      check("rnd_fail_width", 32'(fail), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
